// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out feeder for the 11010 sequence detector.
// WIDTH-bit words arrive over valid/ready, and the block shifts out one bit per
// shift_en strobe. A one-word holding register keeps back-to-back frames gapless.
module piso_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             d_out,
    output logic             bit_valid,
    output logic             frame_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               d_out_q, d_out_d;
    logic               bit_valid_q, bit_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               accept_c;
    logic               last_c;
    logic [WIDTH-1:0]   shifted_c;

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;

        accept_c  = load_valid && ready_q;
        last_c    = shift_en && (cnt_q == LAST_BIT);
        shifted_c = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, shreg_q[WIDTH-1:1]};

        case (state_q)
            IDLE: begin
                // Hold is always empty here, so an accept bypasses straight to shreg
                if (accept_c) begin
                    shreg_d = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_c) begin
                    frame_done_d = 1'b1;
                    cnt_d        = '0;
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept_c) begin
                        shreg_d = data_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (shift_en) begin
                        shreg_d = shifted_c;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                    // accept_c already implies the hold slot is free
                    if (accept_c) begin
                        hold_d      = data_in;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d     = !hold_full_d;
        bit_valid_d = (state_d == SHIFT);
        if (state_d == SHIFT) begin
            d_out_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        end else begin
            d_out_d = IDLE_BIT;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            d_out_q      <= IDLE_BIT;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            d_out_q      <= d_out_d;
            bit_valid_q  <= bit_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready = ready_q;
    assign d_out      = d_out_q;
    assign bit_valid  = bit_valid_q;
    assign frame_done = frame_done_q;

endmodule
